mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the data-memory stage (MEM) and instruction fetch (IF) of the pipeline.
- Arbitrates between the two requests and latches the winning transaction.
- Drives an internal mux2 select so the owner's address, write data and write enable reach memory, then routes the response back.
- Stalls the loser via its missing done; one outstanding transaction at a time.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
d_req  in  1  data-side request; held until d_done
d_we  in  1  data-side write enable (1=store, 0=load)
d_addr  in  AW  data-side address
d_wdata  in  DW  data-side store data
d_done  out  1  one-cycle completion pulse to data side
d_rdata  out  DW  load data to data side
i_req  in  1  fetch request; held until i_done
i_addr  in  AW  fetch address
i_done  out  1  one-cycle completion pulse to fetch side
i_rdata  out  DW  fetched instruction
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_addr  out  AW  address to memory
mem_wdata  out  DW  write data to memory
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory completion (read data valid / write ack)
mem_rdata  in  DW  memory read data
sel  out  1  current owner / mux2 select: 0=data, 1=fetch
busy  out  1  high in any state except IDLE

Behaviour:
- Reset, synchronous and active-high, has priority over all other inputs. All outputs go to 0, state goes to IDLE, latched address/data/we registers are cleared, and the round-robin pointer is cleared.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If d_req or i_req is high, pick the owner by the priority rule.
  - Latch the owner's addr, we and wdata (fetch: we=0, wdata=0). Register sel=owner. Go to REQ.
  - With no request, stay in IDLE.
  - mem_rvalid is ignored in IDLE.
- Fixed priority (default): data wins over fetch when both requests are high.
- REQ:
  - mem_req=1. mem_addr/mem_we/mem_wdata come from the latched registers through a mux2 instance selected by sel.
  - Outputs stay stable until mem_gnt. On mem_gnt go to WAIT.
  - A mem_rvalid arriving in the same cycle as mem_gnt is legal; go directly to RESP.
- WAIT: mem_req=0. On mem_rvalid go to RESP.
- RESP:
  - Pulse the owner's done for exactly one cycle.
  - If the owner's latched we=0, register mem_rdata into the owner's rdata in the RESP entry cycle. For writes, rdata holds its previous value.
  - Always return to IDLE. No arbitration happens in RESP.
- Latency: request seen in IDLE at cycle t → mem_req at t+1. Done comes 1 cycle after the mem_rvalid cycle. Minimum round trip is 3 cycles (gnt and rvalid both at t+1).
- Input changes after latching do not affect the in-flight transaction. A requester may keep req high after its done to issue the next transaction; it is re-arbitrated in IDLE.
- rdata outputs hold their value until the next read completion for the same side.
- sel holds the last owner value while in IDLE.
- Reset in REQ/WAIT/RESP aborts the transaction: no done is pulsed, and a late mem_rvalid is ignored because the block is in IDLE.

Optional Feature:
Macro ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer records the last granted side. When both requests are high in IDLE, the side not granted last wins. The pointer updates on each grant and resets to "fetch last", so data wins the first tie.
- Undefined: fixed priority, data over fetch; fetch can starve under continuous data requests.

Test Plan:
- Reset 3 cycles with random inputs → all outputs 0, busy=0. Release with no requests → remains idle.
- i_req, i_addr=0x0000_0100; mem_gnt on first REQ cycle; mem_rvalid 3 cycles later with mem_rdata=0x0000_0013 → mem_addr=0x100, mem_we=0, sel=1, i_done single pulse, i_rdata=0x13, d_done never set.
- d_req store d_addr=0x200, d_wdata=0xDEAD_BEEF; mem_gnt held low 10 cycles → mem_req=1 and mem_addr/mem_wdata stable all 10 cycles; after gnt+rvalid, d_done pulses and d_rdata is unchanged.
- d_req (load 0x400) and i_req (0x104) asserted together and held → without ARB_RR_EN: data serviced first, then fetch (sel 0 then 1). With ARB_RR_EN and both held for 4 transactions: grant order D, I, D, I.
- Reset asserted in WAIT, then mem_rvalid pulsed 2 cycles later → no done pulse, state IDLE, rdata=0.
- Back-to-back: i_req held across i_done for 3 fetches (0x0, 0x4, 0x8), changing i_addr the cycle after each done → each mem_addr matches, 3 i_done pulses, no request issued in any RESP cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared port.
// The arbiter takes the master modport; the surrounding logic takes slave.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          sel;
  logic          busy;

  modport master (
    input  d_req, d_we, d_addr, d_wdata,
    input  i_req, i_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output d_done, d_rdata, i_done, i_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output sel, busy
  );

  modport slave (
    output d_req, d_we, d_addr, d_wdata,
    output i_req, i_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  d_done, d_rdata, i_done, i_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  sel, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between MEM (data) and IF (fetch).
// Define ARB_RR_EN for round-robin arbitration; default is data-over-fetch.

module mux2 #(
  parameter int W = 1
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.master bus
);
  localparam int MW = 1 + AW + DW;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          d_we_q, d_we_d;
  logic [AW-1:0] d_addr_q, d_addr_d;
  logic [DW-1:0] d_wdata_q, d_wdata_d;
  logic [AW-1:0] i_addr_q, i_addr_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;

  logic          any_req;
  logic          grant;
  logic          pick_i;
  logic          rsp_in;
  logic [MW-1:0] leg_d, leg_i, leg_y;

  assign any_req = bus.d_req | bus.i_req;
  assign grant   = (state_q == IDLE) & any_req;
  assign rsp_in  = ((state_q == REQ) & bus.mem_gnt & bus.mem_rvalid)
                 | ((state_q == WAIT) & bus.mem_rvalid);

`ifdef ARB_RR_EN
  logic rr_q, rr_d;

  // on a tie the side not granted last wins; rr_q=1 means data went last
  assign pick_i = bus.i_req & (~bus.d_req | rr_q);

  // remember the side of every grant
  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = ~pick_i;
  end

  // round-robin pointer, cleared to "fetch last" so data wins the first tie
  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  assign pick_i = bus.i_req & ~bus.d_req;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; a gnt with rvalid in the same cycle skips WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = REQ;
      REQ: begin
        if (bus.mem_gnt) begin
          state_d = bus.mem_rvalid ? RESP : WAIT;
        end
      end
      WAIT: if (bus.mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // latch the winner at grant; capture read data as RESP is entered
  always_comb begin
    sel_d     = sel_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    i_addr_d  = i_addr_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    if (grant) begin
      sel_d = pick_i;
      if (pick_i) begin
        i_addr_d = bus.i_addr;
      end else begin
        d_we_d    = bus.d_we;
        d_addr_d  = bus.d_addr;
        d_wdata_d = bus.d_wdata;
      end
    end
    if (rsp_in) begin
      if (sel_q)        i_rdata_d = bus.mem_rdata;
      else if (!d_we_q) d_rdata_d = bus.mem_rdata;
    end
  end

  // transaction and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      i_addr_q  <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      sel_q     <= sel_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      i_addr_q  <= i_addr_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  // fetch leg never writes
  assign leg_d = {d_we_q, d_addr_q, d_wdata_q};
  assign leg_i = {1'b0, i_addr_q, {DW{1'b0}}};

  mux2 #(.W(MW)) u_mux (
    .s (sel_q),
    .a (leg_d),
    .b (leg_i),
    .y (leg_y)
  );

  assign bus.mem_addr  = leg_y[DW +: AW];
  assign bus.mem_wdata = leg_y[DW-1:0];
  assign bus.sel       = sel_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_rdata   = i_rdata_q;

  // per-state outputs: request in REQ, owner's done pulse in RESP
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.d_done  = 1'b0;
    bus.i_done  = 1'b0;
    bus.busy    = (state_q != IDLE);
    unique case (state_q)
      REQ: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = leg_y[MW-1];
      end
      RESP: begin
        bus.d_done = ~sel_q;
        bus.i_done = sel_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared memory port arbiter.
// Reacts like a memory with programmable grant and response delays.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic        side;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int d_cnt = 0;
  int i_cnt = 0;
  int resp_req_cnt = 0;
  int unstable = 0;
  int gnt_wait = 0;
  int rv_wait = 0;
  bit resp_en = 1'b0;
  bit noise = 1'b0;
  txn_t act_q[$];
  txn_t exp_q[$];
  int done_cyc_q[$];
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] exp_i_rdata = '0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h13;
    return a ^ 32'hC0DE_0000;
  endfunction

  // memory responder
  initial begin : responder
    txn_t t;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (noise) begin
        bus.mem_gnt = 1'($urandom);
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata = $urandom;
      end else if (resp_en && bus.mem_req === 1'b1) begin
        t = '{side: bus.sel, we: bus.mem_we,
              addr: bus.mem_addr, wdata: bus.mem_wdata};
        for (int k = 1; k < gnt_wait; k++) begin
          @(negedge clk);
          if ({bus.mem_req, bus.sel, bus.mem_we, bus.mem_addr,
               bus.mem_wdata} !== {1'b1, t}) unstable++;
        end
        act_q.push_back(t);
        bus.mem_gnt = 1'b1;
        if (rv_wait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_model(t.addr);
        end
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (rv_wait > 0) begin
          repeat (rv_wait - 1) @(negedge clk);
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mem_model(t.addr);
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
        end
      end else begin
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
      end
    end
  end

  // event monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.d_done === 1'b1) d_cnt++;
      if (bus.i_done === 1'b1) begin
        i_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (bus.mem_req === 1'b1 &&
          (bus.d_done === 1'b1 || bus.i_done === 1'b1)) resp_req_cnt++;
    end
  end

  task automatic wait_done(input int budget,
                           output bit dd, output bit di, output bit to);
    dd = 1'b0;
    di = 1'b0;
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.d_done === 1'b1 || bus.i_done === 1'b1) begin
        dd = bus.d_done;
        di = bus.i_done;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    noise = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.d_req = 1'($urandom);
      bus.d_we = 1'($urandom);
      bus.d_addr = $urandom;
      bus.d_wdata = $urandom;
      bus.i_req = 1'($urandom);
      bus.i_addr = $urandom;
    end
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.mem_we, bus.d_done, bus.i_done, bus.sel,
         bus.busy} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.mem_req, bus.mem_we, bus.d_done, bus.i_done, bus.sel,
                bus.busy});
    else n_pass++;
    n_chk++;
    if (bus.mem_addr !== 32'h0)
      $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr);
    else n_pass++;
    n_chk++;
    if (bus.mem_wdata !== 32'h0)
      $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata);
    else n_pass++;
    n_chk++;
    if (bus.d_rdata !== 32'h0)
      $display("FAIL reset_d_rdata got %h want 0", bus.d_rdata);
    else n_pass++;
    n_chk++;
    if (bus.i_rdata !== 32'h0)
      $display("FAIL reset_i_rdata got %h want 0", bus.i_rdata);
    else n_pass++;
    noise = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL idle_busy got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.mem_req !== 1'b0)
      $display("FAIL idle_mem_req got %b want 0", bus.mem_req);
    else n_pass++;
    n_chk++;
    if ({bus.d_done, bus.i_done} !== 2'b00)
      $display("FAIL idle_done got %b want 00", {bus.d_done, bus.i_done});
    else n_pass++;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
  endtask

  task automatic test_fetch();
    bit dd, di, to;
    int d0, i0;
    txn_t got, want;
    resp_en = 1'b1;
    gnt_wait = 0;
    rv_wait = 3;
    d0 = d_cnt;
    i0 = i_cnt;
    act_q.delete();
    exp_q.push_back('{side: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_i_rdata = mem_model(32'h100);
    @(posedge clk);
    #1;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h100;
    wait_done(40, dd, di, to);
    n_chk++;
    if (to || dd || !di)
      $display("FAIL fetch_done got d%b i%b to%b want d0 i1 to0", dd, di, to);
    else n_pass++;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    want = exp_q.pop_front();
    got = 'x;
    if (act_q.size() > 0) got = act_q.pop_front();
    n_chk++;
    if (got !== want)
      $display("FAIL fetch_txn got %h want %h", got, want);
    else n_pass++;
    n_chk++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL fetch_rdata got %h want %h", bus.i_rdata, exp_i_rdata);
    else n_pass++;
    n_chk++;
    if (i_cnt - i0 != 1)
      $display("FAIL fetch_pulses got %0d want 1", i_cnt - i0);
    else n_pass++;
    n_chk++;
    if (d_cnt != d0)
      $display("FAIL fetch_no_d_done got %0d want 0", d_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_store_stall();
    bit dd, di, to;
    txn_t got, want;
    gnt_wait = 10;
    rv_wait = 0;
    unstable = 0;
    act_q.delete();
    exp_q.push_back('{side: 1'b0, we: 1'b1, addr: 32'h200,
                      wdata: 32'hDEAD_BEEF});
    @(posedge clk);
    #1;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    bus.d_addr = 32'hBAD0;
    bus.d_wdata = 32'h0;
    wait_done(60, dd, di, to);
    n_chk++;
    if (to || !dd || di)
      $display("FAIL store_done got d%b i%b to%b want d1 i0 to0", dd, di, to);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (unstable != 0)
      $display("FAIL store_stable got %0d unstable cycles want 0", unstable);
    else n_pass++;
    want = exp_q.pop_front();
    got = 'x;
    if (act_q.size() > 0) got = act_q.pop_front();
    n_chk++;
    if (got !== want)
      $display("FAIL store_txn got %h want %h", got, want);
    else n_pass++;
    n_chk++;
    if (bus.d_rdata !== exp_d_rdata)
      $display("FAIL store_rdata_hold got %h want %h",
               bus.d_rdata, exp_d_rdata);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    bit dd, di, to;
    bit ord[$];
    txn_t got, want;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
    gnt_wait = 0;
    rv_wait = 1;
    act_q.delete();
`ifdef ARB_RR_EN
    ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    ord = '{1'b0, 1'b1};
`endif
    foreach (ord[k]) begin
      if (ord[k]) exp_q.push_back('{1'b1, 1'b0, 32'h104, 32'h0});
      else        exp_q.push_back('{1'b0, 1'b0, 32'h400, 32'h0});
    end
    bus.d_we = 1'b0;
    bus.d_addr = 32'h400;
    bus.d_wdata = 32'h0;
    bus.i_addr = 32'h104;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    foreach (ord[k]) begin
      wait_done(40, dd, di, to);
      n_chk++;
      if (to || di !== ord[k] || dd !== !ord[k])
        $display("FAIL arb_order_%0d got d%b i%b to%b want i%b",
                 k, dd, di, to, ord[k]);
      else n_pass++;
      @(posedge clk);
      #1;
`ifndef ARB_RR_EN
      if (dd) bus.d_req = 1'b0;
`endif
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    foreach (ord[k]) begin
      want = exp_q.pop_front();
      got = 'x;
      if (act_q.size() > 0) got = act_q.pop_front();
      n_chk++;
      if (got !== want)
        $display("FAIL arb_txn_%0d got %h want %h", k, got, want);
      else n_pass++;
    end
    exp_d_rdata = mem_model(32'h400);
    exp_i_rdata = mem_model(32'h104);
    n_chk++;
    if (bus.d_rdata !== exp_d_rdata)
      $display("FAIL arb_d_rdata got %h want %h", bus.d_rdata, exp_d_rdata);
    else n_pass++;
    n_chk++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL arb_i_rdata got %h want %h", bus.i_rdata, exp_i_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    int d0, i0;
    gnt_wait = 0;
    rv_wait = 4;
    act_q.delete();
    exp_q.delete();
    d0 = d_cnt;
    i0 = i_cnt;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h300;
    @(posedge clk);
    #1 bus.d_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (act_q.size() > 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!seen) $display("FAIL rstwait_gnt got none want grant");
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
    repeat (8) @(negedge clk);
    n_chk++;
    if (d_cnt != d0 || i_cnt != i0)
      $display("FAIL rstwait_done got %0d/%0d want 0/0",
               d_cnt - d0, i_cnt - i0);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL rstwait_busy got %b want 0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.d_rdata !== exp_d_rdata)
      $display("FAIL rstwait_d_rdata got %h want %h",
               bus.d_rdata, exp_d_rdata);
    else n_pass++;
    n_chk++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL rstwait_i_rdata got %h want %h",
               bus.i_rdata, exp_i_rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit dd, di, to;
    int i0, r0;
    txn_t got, want;
    gnt_wait = 0;
    rv_wait = 0;
    act_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{1'b1, 1'b0, 32'(k * 4), 32'h0});
    i0 = i_cnt;
    r0 = resp_req_cnt;
    @(posedge clk);
    #1;
    done_cyc_q.delete();
    bus.i_addr = 32'h0;
    bus.i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(30, dd, di, to);
      n_chk++;
      if (to || !di)
        $display("FAIL b2b_done_%0d got i%b to%b want i1 to0", k, di, to);
      else n_pass++;
      @(posedge clk);
      #1 bus.i_addr = 32'((k + 1) * 4);
    end
    bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      want = exp_q.pop_front();
      got = 'x;
      if (act_q.size() > 0) got = act_q.pop_front();
      n_chk++;
      if (got !== want)
        $display("FAIL b2b_txn_%0d got %h want %h", k, got, want);
      else n_pass++;
    end
    n_chk++;
    if (i_cnt - i0 != 3)
      $display("FAIL b2b_pulses got %0d want 3", i_cnt - i0);
    else n_pass++;
    n_chk++;
    if (resp_req_cnt != r0)
      $display("FAIL b2b_req_in_resp got %0d want 0", resp_req_cnt - r0);
    else n_pass++;
    n_chk++;
    if (done_cyc_q.size() != 3 ||
        done_cyc_q[1] - done_cyc_q[0] != 3 ||
        done_cyc_q[2] - done_cyc_q[1] != 3)
      $display("FAIL b2b_spacing got %0d pulses want 3 spaced by 3",
               done_cyc_q.size());
    else n_pass++;
    exp_i_rdata = mem_model(32'h8);
    n_chk++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL b2b_rdata got %h want %h", bus.i_rdata, exp_i_rdata);
    else n_pass++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    test_reset();
    test_fetch();
    test_store_stall();
    test_arbitration();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
